// File: rtl/axils_wr_ch_if.sv
// AXI4-Lite write channel plus local write bus, bundled for the axils_wr_ch responder.
// The slave modport is the responder's view; master is the view of the surrounding system.
interface axils_wr_ch_if;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic        BVALID;
  logic        BREADY;
  logic [1:0]  BRESP;
  logic        BUS_ENA;
  logic [3:0]  BUS_WSTB;
  logic [31:0] BUS_ADDR;
  logic [31:0] BUS_WDATA;
  logic        BUS_DONE;
  logic        BUS_ERR;

  modport slave (
    input  AWADDR, AWPROT, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WVALID,
    output WREADY,
    output BVALID, BRESP,
    input  BREADY,
    output BUS_ENA, BUS_WSTB, BUS_ADDR, BUS_WDATA,
    input  BUS_DONE, BUS_ERR
  );

  modport master (
    output AWADDR, AWPROT, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WVALID,
    input  WREADY,
    input  BVALID, BRESP,
    output BREADY,
    input  BUS_ENA, BUS_WSTB, BUS_ADDR, BUS_WDATA,
    output BUS_DONE, BUS_ERR
  );
endinterface

// File: rtl/axils_wr_ch.sv
// AXI4-Lite slave write channel: collects AW and W in any order, performs one local bus
// write per transaction (with optional timeout), then returns the B response.
module axils_wr_ch #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter logic [31:0] ADDR_SIZE   = 32'h0000_1000,
  parameter int          BUS_TIMEOUT = 16
) (
  input logic          ACLK,
  input logic          ARESET,
  axils_wr_ch_if.slave bus
);

  localparam int CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [32:0] WIN_LO = {1'b0, ADDR_BASE};
  localparam logic [32:0] WIN_HI = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};

  typedef enum logic [2:0] {IDLE, WAIT_W, WAIT_AW, BUS_REQ, RESP} state_t;

  state_t        state_q;
  logic          awReady_q;
  logic          wReady_q;
  logic          bValid_q;
  logic [1:0]    bResp_q;
  logic          busEna_q;
  logic [3:0]    busWstb_q;
  logic [31:0]   busAddr_q;
  logic [31:0]   busWdata_q;
  logic [31:0]   awAddr_q;
  logic [31:0]   wData_q;
  logic [3:0]    wStrb_q;
  logic [CW-1:0] tmoCnt_q;

  logic          awHs;
  logic          wHs;
  logic          complete;
  logic [31:0]   addrSel;
  logic [31:0]   dataSel;
  logic [3:0]    strbSel;
  logic          inRange;
  logic          timedOut;
  logic          unused_prot;

  assign unused_prot = ^bus.AWPROT;

  // The completing beat may arrive this cycle, so the decision looks through to the live inputs.
  always_comb begin
    awHs     = bus.AWVALID & awReady_q;
    wHs      = bus.WVALID & wReady_q;
    complete = ((state_q == IDLE) && awHs && wHs) ||
               ((state_q == WAIT_W) && wHs) ||
               ((state_q == WAIT_AW) && awHs);
    addrSel  = (state_q == WAIT_W) ? awAddr_q : bus.AWADDR;
    dataSel  = (state_q == WAIT_AW) ? wData_q : bus.WDATA;
    strbSel  = (state_q == WAIT_AW) ? wStrb_q : bus.WSTRB;
    inRange  = ({1'b0, addrSel} >= WIN_LO) && ({1'b0, addrSel} < WIN_HI);
    timedOut = (BUS_TIMEOUT != 0) && (tmoCnt_q == CW'(BUS_TIMEOUT - 1));
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= IDLE;
      awReady_q  <= 1'b0;
      wReady_q   <= 1'b0;
      bValid_q   <= 1'b0;
      bResp_q    <= 2'b00;
      busEna_q   <= 1'b0;
      busWstb_q  <= 4'h0;
      busAddr_q  <= 32'h0;
      busWdata_q <= 32'h0;
      awAddr_q   <= 32'h0;
      wData_q    <= 32'h0;
      wStrb_q    <= 4'h0;
      tmoCnt_q   <= '0;
    end else if (complete) begin
      awReady_q <= 1'b0;
      wReady_q  <= 1'b0;
      if (!inRange) begin
        state_q  <= RESP;
        bValid_q <= 1'b1;
        bResp_q  <= 2'b11;
      end else if (strbSel == 4'h0) begin
        state_q  <= RESP;
        bValid_q <= 1'b1;
        bResp_q  <= 2'b00;
      end else begin
        state_q    <= BUS_REQ;
        busEna_q   <= 1'b1;
        busAddr_q  <= {addrSel[31:2], 2'b00};
        busWdata_q <= dataSel;
        busWstb_q  <= strbSel;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (awHs) begin
            awAddr_q  <= bus.AWADDR;
            awReady_q <= 1'b0;
            state_q   <= WAIT_W;
          end else if (wHs) begin
            wData_q  <= bus.WDATA;
            wStrb_q  <= bus.WSTRB;
            wReady_q <= 1'b0;
            state_q  <= WAIT_AW;
          end else begin
            awReady_q <= 1'b1;
            wReady_q  <= 1'b1;
          end
        end
        WAIT_W, WAIT_AW: begin
        end
        BUS_REQ: begin
          // BUS_DONE wins over a timeout expiring in the same cycle.
          if (bus.BUS_DONE) begin
            busEna_q <= 1'b0;
            bValid_q <= 1'b1;
            bResp_q  <= bus.BUS_ERR ? 2'b10 : 2'b00;
            tmoCnt_q <= '0;
            state_q  <= RESP;
          end else if (timedOut) begin
            busEna_q <= 1'b0;
            bValid_q <= 1'b1;
            bResp_q  <= 2'b10;
            tmoCnt_q <= '0;
            state_q  <= RESP;
          end else begin
            tmoCnt_q <= tmoCnt_q + CW'(1);
          end
        end
        RESP: begin
          if (bus.BREADY) begin
            bValid_q  <= 1'b0;
            bResp_q   <= 2'b00;
            awReady_q <= 1'b1;
            wReady_q  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.AWREADY   = awReady_q;
  assign bus.WREADY    = wReady_q;
  assign bus.BVALID    = bValid_q;
  assign bus.BRESP     = bResp_q;
  assign bus.BUS_ENA   = busEna_q;
  assign bus.BUS_WSTB  = busWstb_q;
  assign bus.BUS_ADDR  = busAddr_q;
  assign bus.BUS_WDATA = busWdata_q;

endmodule

// File: tb/tb_axils_wr_ch.sv
// Scoreboard bench for axils_wr_ch: stimulus pushes expected local-bus accesses and B
// responses into queues, independent monitors pop and compare when the DUT presents them.
module tb_axils_wr_ch;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } busExp_t;

  logic ACLK;
  logic ARESET;
  axils_wr_ch_if axi();

  axils_wr_ch #(
    .ADDR_BASE(32'h0000_0000),
    .ADDR_SIZE(32'h0000_1000),
    .BUS_TIMEOUT(16)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .bus(axi)
  );

  int total = 0;
  int bad = 0;
  busExp_t expBus[$];
  logic [1:0] expB[$];
  busExp_t busItem;
  logic [1:0] bItem;

  int doneDelay = 2;
  logic doneErr = 1'b0;
  logic noDone = 1'b0;
  int respCnt = 0;

  logic prevEna = 1'b0;
  int curLen = 0;
  int lastEnaLen = 0;
  int busPulses = 0;

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Local bus responder: raises BUS_DONE on the doneDelay-th cycle of a BUS_ENA pulse.
  initial begin
    axi.BUS_DONE = 1'b0;
    axi.BUS_ERR  = 1'b0;
    forever begin
      @(posedge ACLK);
      #1;
      if (axi.BUS_ENA) begin
        respCnt++;
        axi.BUS_DONE = !noDone && (respCnt == doneDelay);
        axi.BUS_ERR  = doneErr && axi.BUS_DONE;
      end else begin
        respCnt = 0;
        axi.BUS_DONE = 1'b0;
        axi.BUS_ERR  = 1'b0;
      end
    end
  end

  // Local bus monitor: checks each new access and measures pulse length.
  always @(negedge ACLK) begin
    if (axi.BUS_ENA) begin
      if (!prevEna) begin
        busPulses++;
        if (expBus.size() == 0) begin
          checkOutput("bus_unexpected", 32'd1, 32'd0);
        end else begin
          busItem = expBus.pop_front();
          checkOutput("bus_addr", axi.BUS_ADDR, busItem.addr);
          checkOutput("bus_wdata", axi.BUS_WDATA, busItem.data);
          checkOutput("bus_wstb", {28'h0, axi.BUS_WSTB}, {28'h0, busItem.strb});
        end
      end
      curLen++;
    end else if (prevEna) begin
      lastEnaLen = curLen;
      curLen = 0;
    end
    prevEna = axi.BUS_ENA;
  end

  // B monitor: compares BRESP at every handshake.
  always @(negedge ACLK) begin
    if (!ARESET && axi.BVALID && axi.BREADY) begin
      if (expB.size() == 0) begin
        checkOutput("b_unexpected", 32'd1, 32'd0);
      end else begin
        bItem = expB.pop_front();
        checkOutput("b_resp", {30'h0, axi.BRESP}, {30'h0, bItem});
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int awDelay, input int wDelay);
    fork
      begin
        logic rdy;
        bit ok;
        ok = 1'b0;
        repeat (awDelay) @(posedge ACLK);
        if (awDelay > 0) #1;
        axi.AWADDR  = addr;
        axi.AWVALID = 1'b1;
        for (int i = 0; i < 100; i++) begin
          @(negedge ACLK);
          rdy = axi.AWREADY;
          @(posedge ACLK);
          #1;
          if (rdy) begin
            ok = 1'b1;
            break;
          end
        end
        axi.AWVALID = 1'b0;
        if (!ok) checkOutput("aw_accept", 32'd0, 32'd1);
      end
      begin
        logic rdy;
        bit ok;
        ok = 1'b0;
        repeat (wDelay) @(posedge ACLK);
        if (wDelay > 0) #1;
        axi.WDATA  = data;
        axi.WSTRB  = strb;
        axi.WVALID = 1'b1;
        for (int i = 0; i < 100; i++) begin
          @(negedge ACLK);
          rdy = axi.WREADY;
          @(posedge ACLK);
          #1;
          if (rdy) begin
            ok = 1'b1;
            break;
          end
        end
        axi.WVALID = 1'b0;
        if (!ok) checkOutput("w_accept", 32'd0, 32'd1);
      end
    join
  endtask

  // Waits for a B handshake, returns how many negedges it took, then checks ready recovery.
  task automatic waitB(input string name, output int cycles);
    bit found;
    found = 1'b0;
    cycles = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge ACLK);
      if (axi.BVALID && axi.BREADY) begin
        found = 1'b1;
        cycles = i;
        break;
      end
    end
    if (!found) checkOutput({name, "_b_timeout"}, 32'd0, 32'd1);
    @(posedge ACLK);
    #1;
    @(negedge ACLK);
    checkOutput({name, "_awready_back"}, {31'h0, axi.AWREADY}, 32'd1);
    checkOutput({name, "_wready_back"}, {31'h0, axi.WREADY}, 32'd1);
    checkOutput({name, "_bvalid_low"}, {31'h0, axi.BVALID}, 32'd0);
  endtask

  task automatic checkWaitReadies(input string name, input logic awExp, input logic wExp);
    @(posedge ACLK);
    #1;
    @(negedge ACLK);
    checkOutput({name, "_awready"}, {31'h0, axi.AWREADY}, {31'h0, awExp});
    checkOutput({name, "_wready"}, {31'h0, axi.WREADY}, {31'h0, wExp});
  endtask

  initial begin
    int cyc;
    int pulsesBefore;
    bit seen;
    ARESET      = 1'b1;
    axi.AWADDR  = 32'h0;
    axi.AWPROT  = 3'b000;
    axi.AWVALID = 1'b0;
    axi.WDATA   = 32'h0;
    axi.WSTRB   = 4'h0;
    axi.WVALID  = 1'b0;
    axi.BREADY  = 1'b1;

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    checkOutput("rst_awready", {31'h0, axi.AWREADY}, 32'd0);
    checkOutput("rst_wready", {31'h0, axi.WREADY}, 32'd0);
    checkOutput("rst_bvalid", {31'h0, axi.BVALID}, 32'd0);
    checkOutput("rst_bresp", {30'h0, axi.BRESP}, 32'd0);
    checkOutput("rst_bus_ena", {31'h0, axi.BUS_ENA}, 32'd0);
    checkOutput("rst_bus_addr", axi.BUS_ADDR, 32'd0);
    checkOutput("rst_bus_wdata", axi.BUS_WDATA, 32'd0);
    checkOutput("rst_bus_wstb", {28'h0, axi.BUS_WSTB}, 32'd0);
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    checkOutput("post_rst_awready_still_low", {31'h0, axi.AWREADY}, 32'd0);
    checkWaitReadies("post_rst", 1'b1, 1'b1);

    // Simultaneous AW and W, done one cycle after BUS_ENA rises.
    @(posedge ACLK);
    #1;
    expBus.push_back('{32'h10, 32'hDEADBEEF, 4'hF});
    expB.push_back(2'b00);
    applyStimulus(32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    @(negedge ACLK);
    checkOutput("t1_ena_latency", {31'h0, axi.BUS_ENA}, 32'd1);
    waitB("t1", cyc);
    checkOutput("t1_ena_len", lastEnaLen, 32'd2);

    // AW first, W three cycles later.
    @(posedge ACLK);
    #1;
    expBus.push_back('{32'h20, 32'h12345678, 4'h3});
    expB.push_back(2'b00);
    fork
      applyStimulus(32'h23, 32'h12345678, 4'h3, 0, 3);
      checkWaitReadies("t2_wait", 1'b0, 1'b1);
    join
    waitB("t2", cyc);

    // W first, AW two cycles later, local error, BREADY held low for five cycles.
    @(posedge ACLK);
    #1;
    doneErr = 1'b1;
    axi.BREADY = 1'b0;
    expBus.push_back('{32'h104, 32'hA5A5A5A5, 4'hF});
    expB.push_back(2'b10);
    fork
      applyStimulus(32'h104, 32'hA5A5A5A5, 4'hF, 2, 0);
      checkWaitReadies("t3_wait", 1'b1, 1'b0);
    join
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (axi.BVALID) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("t3_bvalid_seen", {31'h0, seen}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      checkOutput("t3_bvalid_hold", {31'h0, axi.BVALID}, 32'd1);
      checkOutput("t3_bresp_hold", {30'h0, axi.BRESP}, 32'd2);
    end
    @(posedge ACLK);
    #1;
    axi.BREADY = 1'b1;
    waitB("t3", cyc);
    doneErr = 1'b0;

    // Local bus never completes: timeout after 16 cycles.
    @(posedge ACLK);
    #1;
    noDone = 1'b1;
    expBus.push_back('{32'h200, 32'h0BADF00D, 4'hC});
    expB.push_back(2'b10);
    applyStimulus(32'h200, 32'h0BADF00D, 4'hC, 0, 0);
    waitB("t4", cyc);
    checkOutput("t4_ena_len", lastEnaLen, 32'd16);
    noDone = 1'b0;

    // Out of range: DECERR next cycle, no local access.
    @(posedge ACLK);
    #1;
    pulsesBefore = busPulses;
    expB.push_back(2'b11);
    applyStimulus(32'h1000, 32'h11111111, 4'hF, 0, 0);
    waitB("t5a", cyc);
    checkOutput("t5a_b_latency", cyc, 32'd0);
    checkOutput("t5a_no_bus", busPulses, pulsesBefore);

    // Zero strobes: OKAY with no local access.
    @(posedge ACLK);
    #1;
    expB.push_back(2'b00);
    applyStimulus(32'h4, 32'h22222222, 4'h0, 0, 0);
    waitB("t5b", cyc);
    checkOutput("t5b_b_latency", cyc, 32'd0);
    checkOutput("t5b_no_bus", busPulses, pulsesBefore);

    // Reset during BUS_REQ abandons the transaction.
    @(posedge ACLK);
    #1;
    noDone = 1'b1;
    expBus.push_back('{32'h30, 32'hCAFEF00D, 4'hF});
    applyStimulus(32'h30, 32'hCAFEF00D, 4'hF, 0, 0);
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b1;
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    checkOutput("t6_ena_dropped", {31'h0, axi.BUS_ENA}, 32'd0);
    checkOutput("t6_bvalid_low", {31'h0, axi.BVALID}, 32'd0);
    checkWaitReadies("t6_recover", 1'b1, 1'b1);
    noDone = 1'b0;
    @(posedge ACLK);
    #1;
    expBus.push_back('{32'h44, 32'h600DD00D, 4'h5});
    expB.push_back(2'b00);
    applyStimulus(32'h47, 32'h600DD00D, 4'h5, 0, 0);
    waitB("t6_next", cyc);

    repeat (3) @(posedge ACLK);
    checkOutput("exp_bus_drained", expBus.size(), 32'd0);
    checkOutput("exp_b_drained", expB.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] global timeout");
  end

endmodule
